mem_responder: RTL and testbench

Memory-side responder for the MAR/MDR memory handshake. The memory-access FSM asserts `memEN` with `RW`, a MAR address and MDR write data. This block stalls for a configurable number of wait states, performs the access on an internal single-port array, and asserts `MFC` to complete the transfer. It is the far end of the `memEN`/`MFC` interface, between the MAR/MDR registers and the storage array.

---
 rtl/mem_responder.sv | 136 +++++++++++++
 tb/tb_mem_responder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the MAR/MDR memEN/MFC handshake.
// Accepts a request from IDLE and latches address, data and direction.
// It then stalls WAIT_CYCLES states, performs the access on an internal
// single-port array, and holds MFC until the initiator drops memEN.
// Optional feature: define MEM_RESPONDER_RANGE_ERR_EN to add the range_err
// output. range_err flags out-of-range accesses alongside MFC.
module mem_responder #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memEN,
  input  logic              RW,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
`ifdef MEM_RESPONDER_RANGE_ERR_EN
  output logic              range_err,
`endif
  output logic              MFC
);

  localparam int                IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] DEPTH_A   = ADDR_W'(DEPTH);
  localparam logic [3:0]        WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK
  } state_t;

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic [ADDR_W-1:0] addrLatch_q;
  logic [DATA_W-1:0] dataLatch_q;
  logic              rwLatch_q;
  logic              mfc_q;
  logic [DATA_W-1:0] dataOut_q;
`ifdef MEM_RESPONDER_RANGE_ERR_EN
  logic              rangeErr_q;
`endif

  logic [DATA_W-1:0] mem [DEPTH];

  logic              inRange;
  logic [IDX_W-1:0]  memIdx;
  logic              accessFire;
  logic              writeEn;
  logic [DATA_W-1:0] rdData;

  // The access always uses the latched request, never the live inputs.
  // The counter runs down to zero, so the access edge lands WAIT_CYCLES+1
  // edges after acceptance, and a zero-wait build still spends one cycle
  // in WAIT.
  assign inRange    = (addrLatch_q < DEPTH_A);
  assign memIdx     = addrLatch_q[IDX_W-1:0];
  assign accessFire = (state_q == S_WAIT) && (cnt_q == 4'd0) && memEN;
  assign writeEn    = accessFire && !rwLatch_q && inRange;
  assign rdData     = inRange ? mem[memIdx] : '0;

  assign MFC      = mfc_q;
  assign data_out = dataOut_q;
`ifdef MEM_RESPONDER_RANGE_ERR_EN
  assign range_err = rangeErr_q;
`endif

  // Storage array: written only on a completed in-range store, never reset.
  always_ff @(posedge clk) begin
    if (writeEn) begin
      mem[memIdx] <= dataLatch_q;
    end
  end

  // Handshake FSM with registered MFC/data_out.
  // Reset drops everything except the array.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      addrLatch_q <= '0;
      dataLatch_q <= '0;
      rwLatch_q   <= 1'b0;
      mfc_q       <= 1'b0;
      dataOut_q   <= '0;
`ifdef MEM_RESPONDER_RANGE_ERR_EN
      rangeErr_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (memEN) begin
            addrLatch_q <= addr;
            dataLatch_q <= data_in;
            rwLatch_q   <= RW;
            cnt_q       <= WAIT_INIT;
            state_q     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!memEN) begin
            state_q <= S_IDLE;
          end else if (cnt_q == 4'd0) begin
            state_q <= S_ACK;
            mfc_q   <= 1'b1;
            if (rwLatch_q) begin
              dataOut_q <= rdData;
            end
`ifdef MEM_RESPONDER_RANGE_ERR_EN
            rangeErr_q <= !inRange;
`endif
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_ACK: begin
          if (!memEN) begin
            state_q <= S_IDLE;
            mfc_q   <= 1'b0;
`ifdef MEM_RESPONDER_RANGE_ERR_EN
            rangeErr_q <= 1'b0;
`endif
          end
        end
        default: begin
          state_q <= S_IDLE;
          mfc_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed, scoreboard-checked bench for mem_responder.
// Two instances share stimulus: dutA with WAIT_CYCLES=2, dutB with WAIT_CYCLES=0.
// sel steers memEN to one of them.
`timescale 1ns/1ps
module tb_mem_responder;

  localparam int AW     = 16;
  localparam int DW     = 16;
  localparam int WAIT_A = 2;
  localparam int WAIT_B = 0;

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
    int            mfcEdge;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          memEn;
  logic          sel;
  logic          rw;
  logic [AW-1:0] addr;
  logic [DW-1:0] din;
  logic          memEnA, memEnB;
  logic [DW-1:0] doutA, doutB;
  logic          mfcA, mfcB;
  logic          mfcSel;
  logic [DW-1:0] doutSel;
`ifdef MEM_RESPONDER_RANGE_ERR_EN
  logic          errA, errB, errSel;
`endif

  exp_t          expQ[$];
  logic [DW-1:0] lastRd [2];
  int            edgeCnt     = 0;
  int            vectors     = 0;
  int            miscompares = 0;
  logic          mfcPrev     = 1'b0;

  assign memEnA  = memEn & ~sel;
  assign memEnB  = memEn & sel;
  assign mfcSel  = sel ? mfcB : mfcA;
  assign doutSel = sel ? doutB : doutA;
`ifdef MEM_RESPONDER_RANGE_ERR_EN
  assign errSel  = sel ? errB : errA;
`endif

  // Free-running clock and rising-edge counter used for latency checks
  always #5 clk = ~clk;
  always @(posedge clk) edgeCnt <= edgeCnt + 1;

  mem_responder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(256), .WAIT_CYCLES(WAIT_A)) dutA (
    .clk(clk), .rst(rst), .memEN(memEnA), .RW(rw), .addr(addr), .data_in(din),
    .data_out(doutA),
`ifdef MEM_RESPONDER_RANGE_ERR_EN
    .range_err(errA),
`endif
    .MFC(mfcA)
  );

  mem_responder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(256), .WAIT_CYCLES(WAIT_B)) dutB (
    .clk(clk), .rst(rst), .memEN(memEnB), .RW(rw), .addr(addr), .data_in(din),
    .data_out(doutB),
`ifdef MEM_RESPONDER_RANGE_ERR_EN
    .range_err(errB),
`endif
    .MFC(mfcB)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at edge %0d", name, act, expv, edgeCnt);
    end
  endtask

  // Monitor: on every MFC rising edge, pop the oldest expectation and compare
  always @(negedge clk) begin
    exp_t e;
    if (rst && mfcSel && !mfcPrev) begin
      if (expQ.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpectedMfc: got MFC=1, expected no completion at edge %0d", edgeCnt);
      end else begin
        e = expQ.pop_front();
        checkOutput("mfcLatency", edgeCnt, e.mfcEdge);
        checkOutput("dataOut", {16'h0, doutSel}, {16'h0, e.data});
`ifdef MEM_RESPONDER_RANGE_ERR_EN
        checkOutput("rangeErr", {31'h0, errSel}, {31'h0, e.err});
`endif
      end
    end
    mfcPrev = mfcSel;
  end

  // mode 0: normal transfer, 1: abort by memEN drop in WAIT,
  // 2: reset asserted in WAIT, 3: reset asserted in ACK.
  task automatic applyStimulus(input int mode, input logic isRead, input logic [AW-1:0] a,
                               input logic [DW-1:0] d, input logic [DW-1:0] rdExp,
                               input logic expErr, input int hold);
    exp_t e;
    int   i;
    @(negedge clk);
    memEn = 1'b1;
    rw    = isRead;
    addr  = a;
    din   = d;
    if (mode == 0 || mode == 3) begin
      e.data    = isRead ? rdExp : lastRd[sel];
      e.err     = expErr;
      e.mfcEdge = edgeCnt + 2 + (sel ? WAIT_B : WAIT_A);
      expQ.push_back(e);
      if (isRead) lastRd[sel] = rdExp;
    end
    @(negedge clk);
    if (mode == 1) begin
      memEn = 1'b0;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        checkOutput("abortNoMfc", {31'h0, mfcSel}, 32'h0);
      end
      checkOutput("abortDout", {16'h0, doutSel}, {16'h0, lastRd[sel]});
      return;
    end
    if (mode == 2) begin
      #2 rst = 1'b0;
      #1;
      checkOutput("rstWaitMfc", {31'h0, mfcSel}, 32'h0);
      checkOutput("rstWaitDout", {16'h0, doutSel}, 32'h0);
      lastRd[0] = '0;
      lastRd[1] = '0;
      memEn = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      return;
    end
    addr = ~a;
    din  = ~d;
    rw   = ~isRead;
    i = 0;
    while (i < 40 && !mfcSel) begin
      @(negedge clk);
      i++;
    end
    if (!mfcSel) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL mfcTimeout: got MFC=0, expected MFC=1 within 40 cycles");
      expQ.delete();
      memEn = 1'b0;
      @(negedge clk);
      return;
    end
    if (mode == 3) begin
      #2 rst = 1'b0;
      #1;
      checkOutput("rstAckMfc", {31'h0, mfcSel}, 32'h0);
      checkOutput("rstAckDout", {16'h0, doutSel}, 32'h0);
      lastRd[0] = '0;
      lastRd[1] = '0;
      memEn = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      return;
    end
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      if (k == 0) begin
        addr = a + 16'd1;
        din  = 16'h2222;
        rw   = 1'b0;
      end
      checkOutput("mfcHeld", {31'h0, mfcSel}, 32'h1);
    end
    memEn = 1'b0;
    @(negedge clk);
    checkOutput("mfcFall", {31'h0, mfcSel}, 32'h0);
`ifdef MEM_RESPONDER_RANGE_ERR_EN
    checkOutput("rangeErrClear", {31'h0, errSel}, 32'h0);
`endif
  endtask

  // Watchdog so the run always terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion, expected $finish before 200us");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus sequence
  initial begin
    rst   = 1'b0;
    memEn = 1'b0;
    sel   = 1'b0;
    rw    = 1'b0;
    addr  = '0;
    din   = '0;
    lastRd[0] = '0;
    lastRd[1] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("resetMfcA", {31'h0, mfcA}, 32'h0);
    checkOutput("resetMfcB", {31'h0, mfcB}, 32'h0);
    checkOutput("resetDoutA", {16'h0, doutA}, 32'h0);
    checkOutput("resetDoutB", {16'h0, doutB}, 32'h0);
`ifdef MEM_RESPONDER_RANGE_ERR_EN
    checkOutput("resetErrA", {31'h0, errA}, 32'h0);
`endif

    // dutA, two wait states
    applyStimulus(0, 1'b0, 16'h0005, 16'hBEEF, 16'h0000, 1'b0, 0);
    applyStimulus(0, 1'b1, 16'h0005, 16'h0000, 16'hBEEF, 1'b0, 0);
    applyStimulus(0, 1'b0, 16'h0021, 16'h3333, 16'h0000, 1'b0, 0);
    applyStimulus(0, 1'b0, 16'h0020, 16'h1111, 16'h0000, 1'b0, 5);
    applyStimulus(0, 1'b1, 16'h0021, 16'h0000, 16'h3333, 1'b0, 0);
    applyStimulus(0, 1'b1, 16'h0020, 16'h0000, 16'h1111, 1'b0, 0);
    applyStimulus(0, 1'b0, 16'h0002, 16'h5555, 16'h0000, 1'b0, 0);
    applyStimulus(1, 1'b0, 16'h0002, 16'hAAAA, 16'h0000, 1'b0, 0);
    applyStimulus(0, 1'b1, 16'h0002, 16'h0000, 16'h5555, 1'b0, 0);
    applyStimulus(0, 1'b0, 16'h00FF, 16'h0F0F, 16'h0000, 1'b0, 0);
    applyStimulus(0, 1'b0, 16'h0000, 16'h0A0A, 16'h0000, 1'b0, 0);
    applyStimulus(0, 1'b1, 16'h00FF, 16'h0000, 16'h0F0F, 1'b0, 0);
    applyStimulus(0, 1'b1, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 0);
    applyStimulus(0, 1'b0, 16'hFFFF, 16'h7777, 16'h0000, 1'b1, 0);
    applyStimulus(0, 1'b0, 16'h0100, 16'h6666, 16'h0000, 1'b1, 0);
    applyStimulus(0, 1'b1, 16'h00FF, 16'h0000, 16'h0F0F, 1'b0, 0);
    applyStimulus(0, 1'b1, 16'h0000, 16'h0000, 16'h0A0A, 1'b0, 0);
    applyStimulus(0, 1'b1, 16'h0100, 16'h0000, 16'h0000, 1'b1, 0);
    applyStimulus(0, 1'b0, 16'h0003, 16'h1357, 16'h0000, 1'b0, 0);
    applyStimulus(2, 1'b0, 16'h0003, 16'h9999, 16'h0000, 1'b0, 0);
    applyStimulus(0, 1'b1, 16'h0003, 16'h0000, 16'h1357, 1'b0, 0);
    applyStimulus(3, 1'b1, 16'h0005, 16'h0000, 16'hBEEF, 1'b0, 0);
    applyStimulus(0, 1'b1, 16'h0020, 16'h0000, 16'h1111, 1'b0, 0);

    // dutB, zero wait states
    @(negedge clk);
    sel = 1'b1;
    applyStimulus(0, 1'b0, 16'h0010, 16'h1234, 16'h0000, 1'b0, 2);
    applyStimulus(0, 1'b1, 16'h0010, 16'h0000, 16'h1234, 1'b0, 0);

    repeat (3) @(negedge clk);
    checkOutput("queueEmpty", expQ.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
